// File: rtl/traffic_phase_sequencer_if.sv
// Countdown-timer link: the sequencer loads a duration and restarts the timer,
// the timer answers with a one-cycle expired pulse.
interface traffic_phase_sequencer_if;
    logic       start_timer;
    logic [6:0] time_param;
    logic       expired;

    modport master (output start_timer, output time_param, input expired);
    modport slave  (input start_timer, input time_param, output expired);
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection phase sequencer driving lamps and a seconds timer.
// Optional pedestrian service (ped_button/walk, longer side green) under TRAFFIC_PED_EN.
module traffic_phase_sequencer #(
    parameter int T_MAIN_MIN = 30,
    parameter int T_YELLOW   = 4,
    parameter int T_ALL_RED  = 2,
    parameter int T_SIDE     = 20
`ifdef TRAFFIC_PED_EN
    ,
    parameter int T_PED      = 25
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    traffic_phase_sequencer_if.master        timer,
    input  logic                             side_car,
`ifdef TRAFFIC_PED_EN
    input  logic                             ped_button,
    output logic                             walk,
`endif
    output logic [2:0]                       main_light,
    output logic [2:0]                       side_light,
    output logic [2:0]                       phase
);

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        CLR_A     = 3'd1,
        SIDE_G    = 3'd2,
        SIDE_Y    = 3'd3,
        CLR_B     = 3'd4,
        MAIN_G    = 3'd5,
        MAIN_WAIT = 3'd6,
        MAIN_Y    = 3'd7
    } state_t;

    // A zero duration would never let the timer expire, so it is clamped to 1.
    function automatic logic [6:0] dur(input int t);
        dur = (t <= 0) ? 7'd1 : 7'(t);
    endfunction

    localparam logic [6:0] D_MAIN_MIN = dur(T_MAIN_MIN);
    localparam logic [6:0] D_YELLOW   = dur(T_YELLOW);
    localparam logic [6:0] D_ALL_RED  = dur(T_ALL_RED);
    localparam logic [6:0] D_SIDE     = dur(T_SIDE);
`ifdef TRAFFIC_PED_EN
    localparam logic [6:0] D_PED      = dur(T_PED);
`endif

    function automatic logic [5:0] lights_of(input state_t s);
        case (s)
            MAIN_G, MAIN_WAIT: lights_of = {3'b001, 3'b100};
            MAIN_Y:            lights_of = {3'b010, 3'b100};
            SIDE_G:            lights_of = {3'b100, 3'b001};
            SIDE_Y:            lights_of = {3'b100, 3'b010};
            default:           lights_of = {3'b100, 3'b100};
        endcase
    endfunction

    state_t     state, state_n;
    logic       start_n;
    logic [6:0] tp_n;
    logic [2:0] main_n, side_n;
    logic       side_req, side_req_n;
    logic       exit_req;
    logic       acc;
`ifdef TRAFFIC_PED_EN
    logic       ped_req, ped_req_n;
    logic       walk_n;
`endif

    assign phase = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= INIT;
            timer.start_timer <= 1'b0;
            timer.time_param  <= 7'd0;
            main_light        <= 3'b100;
            side_light        <= 3'b100;
            side_req          <= 1'b0;
`ifdef TRAFFIC_PED_EN
            ped_req           <= 1'b0;
            walk              <= 1'b0;
`endif
        end else begin
            state             <= state_n;
            timer.start_timer <= start_n;
            timer.time_param  <= tp_n;
            main_light        <= main_n;
            side_light        <= side_n;
            side_req          <= side_req_n;
`ifdef TRAFFIC_PED_EN
            ped_req           <= ped_req_n;
            walk              <= walk_n;
`endif
        end
    end

    // An expired arriving while start_timer is high belongs to the previous load.
    assign acc = timer.expired && !timer.start_timer;

`ifdef TRAFFIC_PED_EN
    assign exit_req = side_req | ped_req;
`else
    assign exit_req = side_req;
`endif

    always_comb begin
        state_n    = state;
        start_n    = 1'b0;
        tp_n       = timer.time_param;
        side_req_n = side_req | side_car;
`ifdef TRAFFIC_PED_EN
        ped_req_n  = ped_req | ped_button;
        walk_n     = walk;
`endif
        case (state)
            INIT: begin
                state_n = CLR_B;
                start_n = 1'b1;
                tp_n    = D_ALL_RED;
            end
            CLR_B: if (acc) begin
                state_n = MAIN_G;
                start_n = 1'b1;
                tp_n    = D_MAIN_MIN;
            end
            MAIN_G: if (acc) begin
                if (exit_req) begin
                    state_n = MAIN_Y;
                    start_n = 1'b1;
                    tp_n    = D_YELLOW;
                end else begin
                    state_n = MAIN_WAIT;
                end
            end
            MAIN_WAIT: if (exit_req) begin
                state_n = MAIN_Y;
                start_n = 1'b1;
                tp_n    = D_YELLOW;
            end
            MAIN_Y: if (acc) begin
                state_n = CLR_A;
                start_n = 1'b1;
                tp_n    = D_ALL_RED;
            end
            CLR_A: if (acc) begin
                state_n    = SIDE_G;
                start_n    = 1'b1;
                tp_n       = D_SIDE;
                side_req_n = side_car;
`ifdef TRAFFIC_PED_EN
                if (ped_req) begin
                    tp_n   = D_PED;
                    walk_n = 1'b1;
                end
                ped_req_n = ped_button;
`endif
            end
            SIDE_G: if (acc) begin
                state_n = SIDE_Y;
                start_n = 1'b1;
                tp_n    = D_YELLOW;
`ifdef TRAFFIC_PED_EN
                walk_n  = 1'b0;
`endif
            end
            SIDE_Y: if (acc) begin
                state_n = CLR_B;
                start_n = 1'b1;
                tp_n    = D_ALL_RED;
            end
            default: state_n = INIT;
        endcase
        {main_n, side_n} = lights_of(state_n);
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench: the bench plays the timer, a scoreboard holds the
// expected phase/duration for every start_timer pulse the sequencer should issue.
`timescale 1ns/1ps
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       side_car = 1'b0;
    logic [2:0] main_light, side_light, phase;
`ifdef TRAFFIC_PED_EN
    logic       ped_button = 1'b0;
    logic       walk;
`endif

    traffic_phase_sequencer_if timer ();

    traffic_phase_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .timer      (timer.master),
        .side_car   (side_car),
`ifdef TRAFFIC_PED_EN
        .ped_button (ped_button),
        .walk       (walk),
`endif
        .main_light (main_light),
        .side_light (side_light),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ph;
        logic [6:0] tp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;

    // Scoreboard: every start_timer pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && reset && timer.start_timer) begin
            exp_t e;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_start: phase=%0d time_param=%0d, required no start_timer", phase, timer.time_param);
            end else begin
                e = sb.pop_front();
                if (phase !== e.ph || timer.time_param !== e.tp) begin
                    n_fail++;
                    $display("FAIL sb_start: phase=%0d time_param=%0d, required phase=%0d time_param=%0d",
                             phase, timer.time_param, e.ph, e.tp);
                end
            end
        end
    end

    task automatic push(input logic [2:0] ph, input logic [6:0] tp);
        exp_t e;
        e.ph = ph;
        e.tp = tp;
        sb.push_back(e);
    endtask

    // One-cycle expired; returns on the negedge where the new phase is visible.
    task automatic pulse_expired();
        @(negedge clk) timer.expired = 1'b1;
        @(negedge clk) timer.expired = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk) reset = 1'b0;
        mon_en = 1'b1;
        #1;
        n_checks++;
        if (main_light !== 3'b100 || side_light !== 3'b100 || phase !== 3'd0 ||
            timer.start_timer !== 1'b0 || timer.time_param !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_immediate: main=%b side=%b phase=%0d start=%b tp=%0d, required 100/100/0/0/0",
                     main_light, side_light, phase, timer.start_timer, timer.time_param);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (main_light !== 3'b100 || side_light !== 3'b100 || phase !== 3'd0 || timer.start_timer !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: main=%b side=%b phase=%0d start=%b, required 100/100/0/0",
                         main_light, side_light, phase, timer.start_timer);
            end
        end
        push(3'd4, 7'd2);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (phase !== 3'd4 || timer.start_timer !== 1'b1 || main_light !== 3'b100 || side_light !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_exit: phase=%0d start=%b main=%b side=%b, required 4/1/100/100",
                     phase, timer.start_timer, main_light, side_light);
        end
        @(negedge clk);
        n_checks++;
        if (timer.start_timer !== 1'b0 || phase !== 3'd4 || timer.time_param !== 7'd2) begin
            n_fail++;
            $display("FAIL reset_start_width: start=%b phase=%0d tp=%0d, required 0/4/2",
                     timer.start_timer, phase, timer.time_param);
        end
    endtask

    task automatic test_cycle_with_car();
        side_car = 1'b1;
        push(3'd5, 7'd30);
        pulse_expired();
        n_checks++;
        if (phase !== 3'd5 || main_light !== 3'b001 || side_light !== 3'b100) begin
            n_fail++;
            $display("FAIL main_green: phase=%0d main=%b side=%b, required 5/001/100", phase, main_light, side_light);
        end
        push(3'd7, 7'd4);
        pulse_expired();
        n_checks++;
        if (phase !== 3'd7 || main_light !== 3'b010 || side_light !== 3'b100) begin
            n_fail++;
            $display("FAIL main_yellow: phase=%0d main=%b side=%b, required 7/010/100", phase, main_light, side_light);
        end
        push(3'd1, 7'd2);
        pulse_expired();
        // Car still present on the SIDE_G entry edge: request survives the clear.
        push(3'd2, 7'd20);
        pulse_expired();
        side_car = 1'b0;
        n_checks++;
        if (phase !== 3'd2 || main_light !== 3'b100 || side_light !== 3'b001) begin
            n_fail++;
            $display("FAIL side_green: phase=%0d main=%b side=%b, required 2/100/001", phase, main_light, side_light);
        end
        push(3'd3, 7'd4);
        pulse_expired();
        n_checks++;
        if (side_light !== 3'b010 || main_light !== 3'b100) begin
            n_fail++;
            $display("FAIL side_yellow: main=%b side=%b, required 100/010", main_light, side_light);
        end
        push(3'd4, 7'd2);
        pulse_expired();
        push(3'd5, 7'd30);
        pulse_expired();
        push(3'd7, 7'd4);
        pulse_expired();
        n_checks++;
        if (phase !== 3'd7) begin
            n_fail++;
            $display("FAIL set_wins_clear: phase=%0d, required 7", phase);
        end
        push(3'd1, 7'd2);  pulse_expired();
        push(3'd2, 7'd20); pulse_expired();
        push(3'd3, 7'd4);  pulse_expired();
        push(3'd4, 7'd2);  pulse_expired();
        push(3'd5, 7'd30); pulse_expired();
    endtask

    task automatic test_main_wait();
        logic hit;
        pulse_expired();
        n_checks++;
        if (phase !== 3'd6 || timer.start_timer !== 1'b0 || main_light !== 3'b001) begin
            n_fail++;
            $display("FAIL main_wait_entry: phase=%0d start=%b main=%b, required 6/0/001",
                     phase, timer.start_timer, main_light);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 20) timer.expired = 1'b1;
            else         timer.expired = 1'b0;
        end
        n_checks++;
        if (phase !== 3'd6) begin
            n_fail++;
            $display("FAIL main_wait_hold: phase=%0d, required 6", phase);
        end
        push(3'd7, 7'd4);
        side_car = 1'b1;
        @(negedge clk) side_car = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 6 && !hit; i++) begin
            @(negedge clk);
            if (phase === 3'd7) hit = 1'b1;
        end
        n_checks++;
        if (!hit || timer.start_timer !== 1'b1 || timer.time_param !== 7'd4) begin
            n_fail++;
            $display("FAIL main_wait_exit: phase=%0d start=%b tp=%0d, required 7/1/4",
                     phase, timer.start_timer, timer.time_param);
        end
    endtask

    // Entered on the MAIN_Y start_timer cycle.
    task automatic test_stale_expired();
        timer.expired = 1'b1;
        @(negedge clk) timer.expired = 1'b0;
        n_checks++;
        if (phase !== 3'd7) begin
            n_fail++;
            $display("FAIL stale_expired: phase=%0d, required 7", phase);
        end
        repeat (9) @(negedge clk);
        push(3'd1, 7'd2);
        pulse_expired();
        n_checks++;
        if (phase !== 3'd1 || main_light !== 3'b100 || side_light !== 3'b100) begin
            n_fail++;
            $display("FAIL late_expired: phase=%0d main=%b side=%b, required 1/100/100", phase, main_light, side_light);
        end
    endtask

    task automatic test_reset_mid_side();
        push(3'd2, 7'd20);
        pulse_expired();
        repeat (3) @(negedge clk);
        n_checks++;
        if (phase !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_reset_side: phase=%0d, required 2", phase);
        end
        test_reset();
    endtask

`ifdef TRAFFIC_PED_EN
    task automatic test_ped();
        logic hit;
        push(3'd5, 7'd30);
        pulse_expired();
        pulse_expired();
        n_checks++;
        if (phase !== 3'd6 || walk !== 1'b0) begin
            n_fail++;
            $display("FAIL ped_wait_entry: phase=%0d walk=%b, required 6/0", phase, walk);
        end
        push(3'd7, 7'd4);
        ped_button = 1'b1;
        @(negedge clk) ped_button = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 6 && !hit; i++) begin
            @(negedge clk);
            if (phase === 3'd7) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL ped_exit_wait: phase=%0d, required 7", phase);
        end
        @(negedge clk);
        push(3'd1, 7'd2);
        pulse_expired();
        push(3'd2, 7'd25);
        pulse_expired();
        repeat (3) @(negedge clk);
        n_checks++;
        if (walk !== 1'b1 || timer.time_param !== 7'd25) begin
            n_fail++;
            $display("FAIL ped_side_green: walk=%b tp=%0d, required 1/25", walk, timer.time_param);
        end
        push(3'd3, 7'd4);
        pulse_expired();
        n_checks++;
        if (walk !== 1'b0) begin
            n_fail++;
            $display("FAIL ped_walk_drop: walk=%b, required 0", walk);
        end
        push(3'd4, 7'd2);  pulse_expired();
        push(3'd5, 7'd30); pulse_expired();
        push(3'd7, 7'd4);
        side_car = 1'b1;
        @(negedge clk) side_car = 1'b0;
        repeat (2) @(negedge clk);
        push(3'd1, 7'd2);  pulse_expired();
        push(3'd2, 7'd20); pulse_expired();
        n_checks++;
        if (walk !== 1'b0 || timer.time_param !== 7'd20) begin
            n_fail++;
            $display("FAIL ped_next_side: walk=%b tp=%0d, required 0/20", walk, timer.time_param);
        end
    endtask
`endif

    initial begin
        timer.expired = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_cycle_with_car();
        test_main_wait();
        test_stale_expired();
        test_reset_mid_side();
`ifdef TRAFFIC_PED_EN
        test_ped();
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d start_timer pulses missing, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
